// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared constants for the boot-time instruction-memory loader.
//   - frame-layout constants (count width, bytes per word, byte/word widths)
//   - FSM state encoding
//   - helper classifying the states that accept stream bytes
package imem_loader_pkg;

    // Frame layout
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned CNT_W          = 16;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BIDX_W         = 2;

    // FSM state encoding
    localparam int unsigned STATE_W = 3;
    localparam logic [2:0] S_CNT_HI = 3'd0;
    localparam logic [2:0] S_CNT_LO = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CSUM   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    // True for every state in which the loader takes bytes from the stream.
    function automatic logic is_rx_state(input logic [STATE_W-1:0] s);
        return (s == S_CNT_HI) || (s == S_CNT_LO) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage : imem_loader_pkg

// File: rtl/imem_word_pack.sv
// imem_word_pack: packs stream bytes into 32-bit big-endian words.
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset; discards any partial word
//   shift_i        a payload byte is being accepted this cycle
//   byte_i         payload byte
//   word_c_o       assembled word (3 buffered bytes + byte_i), valid with word_done_c_o
//   word_done_c_o  combinational strobe: this shift completes a word
module imem_word_pack
    import imem_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              shift_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_c_o,
    output logic              word_done_c_o
);

    localparam int unsigned BUF_W = WORD_W - BYTE_W;

    logic [BUF_W-1:0]  shreg_q, shreg_d;
    logic [BIDX_W-1:0] idx_q, idx_d;

    // Next-state: shift MSB-first, count bytes within the word
    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        if (shift_i) begin
            shreg_d = {shreg_q[BUF_W-BYTE_W-1:0], byte_i};
            idx_d   = idx_q + BIDX_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

    // The 4th byte bypasses the buffer so the word is ready on its accepting edge
    assign word_c_o      = {shreg_q, byte_i};
    assign word_done_c_o = shift_i && (idx_q == BIDX_W'(BYTES_PER_WORD - 1));

endmodule : imem_word_pack

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader writing the instruction memory.
// Accepts a frame CNT_HI, CNT_LO, N*4 payload bytes (words MSB first), CSUM
// (XOR of payload bytes) and writes words to addresses 0..N-1. The CPU is held
// in reset until a full frame with a matching checksum has been written.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   data_i     stream byte
//   valid_i    data_i valid
//   ready_o    loader can accept a byte (registered)
//   wen_o      instruction-memory write enable, one-cycle pulse per word
//   waddr_o    word address, holds until the next write
//   wdata_o    word data, holds until the next write
//   cpu_rst_o  CPU reset, high until the load succeeds
//   done_o     load succeeded (sticky)
//   err_o      load failed (sticky)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [BYTE_W-1:0]     data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  wen_o,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic [WORD_W-1:0]     wdata_o,
    output logic                  cpu_rst_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int unsigned CAPACITY = 1 << ADDR_WIDTH;
    // Word counter must reach 2^ADDR_WIDTH without wrapping
    localparam int unsigned WCNT_W   = ADDR_WIDTH + 1;
    // Comparison width covering both the 16-bit count and the capacity
    localparam int unsigned CMP_W    = CNT_W + 1;

    logic [STATE_W-1:0]    state_q, state_d;
    logic [BYTE_W-1:0]     cnt_hi_q, cnt_hi_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WCNT_W-1:0]     word_cnt_q, word_cnt_d;
    logic [BYTE_W-1:0]     csum_q, csum_d;
    logic                  ready_q, ready_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  accept_c;
    logic                  shift_c;
    logic [CNT_W-1:0]      frame_n_c;
    logic [WORD_W-1:0]     word_c;
    logic                  word_done_c;

    // Byte-to-word packer
    imem_word_pack u_word_pack (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .shift_i       (shift_c),
        .byte_i        (data_i),
        .word_c_o      (word_c),
        .word_done_c_o (word_done_c)
    );

    assign accept_c  = valid_i && ready_q;
    assign frame_n_c = {cnt_hi_q, data_i};

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        cnt_hi_d   = cnt_hi_q;
        cnt_d      = cnt_q;
        word_cnt_d = word_cnt_q;
        csum_d     = csum_q;
        wen_d      = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        shift_c    = 1'b0;

        case (state_q)
            S_CNT_HI: begin
                if (accept_c) begin
                    cnt_hi_d = data_i;
                    state_d  = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (accept_c) begin
                    cnt_d = frame_n_c;
                    if (CMP_W'(frame_n_c) > CMP_W'(CAPACITY)) begin
                        state_d = S_ERR;
                    end else if (frame_n_c == '0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept_c) begin
                    shift_c = 1'b1;
                    csum_d  = csum_q ^ data_i;
                    if (word_done_c) begin
                        wen_d      = 1'b1;
                        waddr_d    = ADDR_WIDTH'(word_cnt_q);
                        wdata_d    = word_c;
                        word_cnt_d = word_cnt_q + WCNT_W'(1);
                        // Last word of the frame just went out
                        if (CMP_W'(word_cnt_q) + CMP_W'(1) == CMP_W'(cnt_q)) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (accept_c) begin
                    state_d = (data_i == csum_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase

        // Status outputs are registered from the next state so they change
        // in the cycle right after the deciding byte is accepted
        ready_d   = is_rx_state(state_d);
        done_d    = (state_d == S_DONE);
        err_d     = (state_d == S_ERR);
        cpu_rst_d = (state_d != S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_CNT_HI;
            cnt_hi_q   <= '0;
            cnt_q      <= '0;
            word_cnt_q <= '0;
            csum_q     <= '0;
            ready_q    <= 1'b0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_hi_q   <= cnt_hi_d;
            cnt_q      <= cnt_d;
            word_cnt_q <= word_cnt_d;
            csum_q     <= csum_d;
            ready_q    <= ready_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign ready_o   = ready_q;
    assign wen_o     = wen_q;
    assign waddr_o   = waddr_q;
    assign wdata_o   = wdata_q;
    assign cpu_rst_o = cpu_rst_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader (ADDR_WIDTH=8): expected writes go into a queue
// when a frame is issued; a monitor pops and compares on every wen_o pulse.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic        wen;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    imem_loader #(.ADDR_WIDTH(8)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .data_i    (data),
        .valid_i   (valid),
        .ready_o   (ready),
        .wen_o     (wen),
        .waddr_o   (waddr),
        .wdata_o   (wdata),
        .cpu_rst_o (cpu_rst),
        .done_o    (done),
        .err_o     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the next expected write
    always @(negedge clk) begin
        if (wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %h data %h expected none", waddr, wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(waddr), 32'(e.addr));
                chk("write_data", wdata, e.data);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [7:0] b, input int gap);
        int tmo;
        valid = 1'b0;
        repeat (gap) @(negedge clk);
        data  = b;
        valid = 1'b1;
        tmo   = 0;
        while (ready !== 1'b1 && tmo < 20) begin
            @(negedge clk);
            tmo++;
        end
        if (tmo >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got ready=%b expected 1", ready);
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic send_frame1(input logic [7:0] last, input logic gaps);
        logic [7:0] bytes [0:10];
        bytes = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                  8'h01, 8'h23, 8'h45, 8'h67, 8'h22};
        bytes[10] = last;
        for (int i = 0; i < 11; i++) begin
            send(bytes[i], gaps ? int'($urandom_range(0, 3)) : 0);
        end
    endtask

    task automatic push_frame1_writes();
        exp_q.push_back('{addr: 8'h00, data: 32'hDEADBEEF});
        exp_q.push_back('{addr: 8'h01, data: 32'h01234567});
    endtask

    task automatic chk_status(input string tag, input logic rdy, input logic dn,
                              input logic er, input logic cr);
        chk({tag, "_ready"},   32'(ready),   32'(rdy));
        chk({tag, "_done"},    32'(done),    32'(dn));
        chk({tag, "_err"},     32'(err),     32'(er));
        chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(cr));
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Leaves reset asserted for one edge, checks reset values, then releases
    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b1;
        data  = 8'hFF;
        @(negedge clk);
        chk_status("rst", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_wen",   32'(wen),   32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata,      32'd0);
        valid = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk("rst_ready_after_release", 32'(ready), 32'd1);
    endtask

    // Hang guard
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        repeat (2) @(negedge clk);

        // Normal load at full rate
        do_reset();
        push_frame1_writes();
        send_frame1(8'h22, 1'b0);
        chk_status("normal", 1'b0, 1'b1, 1'b0, 1'b0);
        chk_drained("normal");

        // Reset mid-frame, then full frame from address 0
        do_reset();
        send(8'h00, 0);
        send(8'h02, 0);
        send(8'hDE, 0);
        do_reset();
        push_frame1_writes();
        send_frame1(8'h22, 1'b0);
        chk_status("midrst", 1'b0, 1'b1, 1'b0, 1'b0);
        chk_drained("midrst");

        // Bad checksum
        do_reset();
        push_frame1_writes();
        send_frame1(8'h23, 1'b0);
        chk_status("badcsum", 1'b0, 1'b0, 1'b1, 1'b1);
        chk_drained("badcsum");

        // Empty program
        do_reset();
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        chk_status("empty", 1'b0, 1'b1, 1'b0, 1'b0);

        // Oversize count: N=257
        do_reset();
        send(8'h01, 0);
        send(8'h01, 0);
        chk_status("oversize", 1'b0, 1'b0, 1'b1, 1'b1);

        // Full capacity: N=256, all-zero payload
        do_reset();
        for (int i = 0; i < 256; i++) exp_q.push_back('{addr: 8'(i), data: 32'h0});
        send(8'h01, 0);
        send(8'h00, 0);
        for (int i = 0; i < 1024; i++) send(8'h00, 0);
        send(8'h00, 0);
        chk_status("full", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("full_last_addr", 32'(waddr), 32'h0000_00FF);
        chk_drained("full");

        // Handshake gaps, then valid held high in S_DONE
        do_reset();
        push_frame1_writes();
        send_frame1(8'h22, 1'b1);
        chk_status("gaps", 1'b0, 1'b1, 1'b0, 1'b0);
        valid = 1'b1;
        data  = 8'h5A;
        repeat (6) begin
            @(negedge clk);
            chk("done_hold_ready", 32'(ready), 32'd0);
        end
        valid = 1'b0;
        chk_status("done_hold", 1'b0, 1'b1, 1'b0, 1'b0);
        chk_drained("gaps");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_imem_loader

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader: the writer side of the instruction memory that the fetch stage reads. It accepts a framed byte stream over a valid/ready handshake and packs the bytes into 32-bit big-endian words. It writes those words to sequential instruction-memory addresses starting at 0. It holds the CPU in reset until a complete frame with a correct checksum has been written.

## Interface
Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity 2^ADDR_WIDTH words; legal range 1..16.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- data_i  in  8  stream byte.
- valid_i  in  1  data_i valid.
- ready_o  out  1  loader can accept a byte.
- wen_o  out  1  instruction-memory write enable, one-cycle pulse per word.
- waddr_o  out  ADDR_WIDTH  word address.
- wdata_o  out  32  word data.
- cpu_rst_o  out  1  CPU reset; high until the load succeeds.
- done_o  out  1  load succeeded; sticky.
- err_o  out  1  load failed; sticky.

## Operation
- Frame format: CNT_HI, CNT_LO, then N×4 payload bytes, then CSUM.
  - N = {CNT_HI, CNT_LO} is an unsigned 16-bit word count.
  - Each word is sent MSB first.
  - CSUM = XOR of all payload bytes only. The count bytes are not included.
- A byte is transferred on a rising edge where valid_i && ready_o.
- States: S_CNT_HI → S_CNT_LO → S_DATA → S_CSUM → S_DONE. S_ERR is reached from S_CNT_LO or S_CSUM.
  - S_CNT_HI: latch the high count byte.
  - S_CNT_LO: latch the low count byte, then branch:
    - N > 2^ADDR_WIDTH → S_ERR.
    - N == 0 → S_CSUM.
    - Otherwise → S_DATA.
  - S_DATA: shift the byte into the word buffer, XOR it into the running checksum, and increment a 2-bit byte index.
    - On the 4th byte, issue a write of the assembled word to address word_cnt, then increment word_cnt.
    - After word N-1 is written → S_CSUM.
  - S_CSUM: compare the received byte with the running checksum.
    - Equal → S_DONE.
    - Not equal → S_ERR.
  - S_DONE: ready_o=0, done_o=1, cpu_rst_o=0.
  - S_ERR: ready_o=0, err_o=1, cpu_rst_o=1.
- S_DONE and S_ERR are terminal. Only rst_i leaves them. Bytes presented in these states are never accepted.
- N == 2^ADDR_WIDTH is legal. The last write goes to address 2^ADDR_WIDTH-1, and waddr_o does not wrap during the frame.
- Words already written before an S_ERR are not rolled back. cpu_rst_o stays high, so they are never executed.
- Reset mid-frame discards any partial word, the count, the checksum and the address. The next frame starts fresh at address 0.

## Timing
- Reset values, asserted the cycle after rst_i is sampled high:
  - ready_o=0, wen_o=0, waddr_o=0, wdata_o=0.
  - cpu_rst_o=1, done_o=0, err_o=0.
  - State = S_CNT_HI.
- ready_o is registered. It is 1 from the first cycle after rst_i is sampled low, and it stays 1 in every receive state, including while valid_i=0.
- Write latency:
  - wen_o rises in the cycle after the edge that accepts the 4th byte of a word, and stays high for exactly one cycle.
  - waddr_o and wdata_o are valid in that same cycle and hold until the next write.
- Consecutive words at full rate produce wen_o pulses 4 cycles apart.
- Terminal-state outputs appear in the cycle after the accepting edge of the deciding byte (CNT_LO or CSUM):
  - done_o, err_o and cpu_rst_o change in that cycle.
  - ready_o falls in that cycle.
- Gaps on valid_i stall the state machine without changing any state.
- rst_i high overrides every simultaneous handshake.

## Structure
- Shared package imem_loader_pkg holds:
  - the state encoding localparams;
  - the frame-layout constants: count width 16, bytes per word 4.
- One sub-module, imem_word_pack, holds the byte-to-word shift register, the 2-bit byte index and the word-complete strobe.
- The control FSM, word/address counter, checksum register and output registers live in imem_loader.

## Test plan
- Normal load, ADDR_WIDTH=8: bytes 00 02 DE AD BE EF 01 23 45 67 22 at full rate.
  - Expect wen_o pulses at (0, 0xDEADBEEF) and (1, 0x01234567).
  - Then done_o=1, cpu_rst_o=0, err_o=0, ready_o=0.
- Bad checksum: the same frame with final byte 0x23.
  - Expect both writes.
  - Then err_o=1, cpu_rst_o=1, done_o=0, ready_o=0.
- Empty program: bytes 00 00 00.
  - Expect no wen_o pulse, then done_o=1 and cpu_rst_o=0.
- Oversize count: bytes 01 01 (N=257, ADDR_WIDTH=8).
  - Expect err_o=1 the cycle after the 2nd byte and no wen_o.
  - Also: N=0x0100 with all-zero payload and CSUM 00 is accepted, and the last write goes to address 0xFF.
- Handshake gaps: frame 1 with random 0–3 idle cycles between bytes, plus valid_i held high in S_DONE.
  - Expect identical writes and result, with no extra bytes accepted.
- Reset mid-frame: assert rst_i after 00 02 DE.
  - Expect all outputs at reset values.
  - Then frame 1 resent: writes land at addresses 0 and 1 with correct data, and done_o=1.
